// File: rtl/ring_pkg.sv
// Purpose: shared state/step encodings and one-hot helpers for the ring observer.
// Latency: none; types and combinational functions only.
// Backpressure: none; nothing here holds state.
package ring_pkg;

  // Helpers take vectors zero-extended to this width, so rings up to 32 bits are supported.
  localparam int MAXW = 32;

  localparam logic [1:0] ST_SYNC_ENC   = 2'b00;
  localparam logic [1:0] ST_ACQ_ENC    = 2'b01;
  localparam logic [1:0] ST_LOCKED_ENC = 2'b10;
  localparam logic [1:0] ST_FAULT_ENC  = 2'b11;

  typedef enum logic [1:0] {
    ST_SYNC   = ST_SYNC_ENC,
    ST_ACQ    = ST_ACQ_ENC,
    ST_LOCKED = ST_LOCKED_ENC,
    ST_FAULT  = ST_FAULT_ENC
  } state_t;

  typedef enum logic [1:0] {
    STEP_ADV,
    STEP_HOLD,
    STEP_BAD_PAT,
    STEP_BAD_ORD
  } step_t;

  // Exactly one bit set; all-zero is not one-hot.
  function automatic logic is_onehot(input logic [MAXW-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAXW'(1))) == '0);
  endfunction

  // Rotate the low 'width' bits left by one: bit i moves to i+1, bit width-1 wraps to 0.
  function automatic logic [MAXW-1:0] rotl1(input logic [MAXW-1:0] vec, input int width);
    logic [MAXW-1:0] r;
    r = '0;
    for (int i = 1; i < MAXW; i++) begin
      if (i < width) r[i] = vec[i-1];
    end
    for (int i = 0; i < MAXW; i++) begin
      if (i == width - 1) r[0] = vec[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Purpose: one-hot to binary encoder for the sampled ring vector.
// Latency: combinational.
// Backpressure: none.
// Ports: onehot (WIDTH) in; phase ($clog2(WIDTH)) out, 0 unless onehot is one-hot;
//        phase_valid out, high when onehot has exactly one bit set.
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         onehot,
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic                     phase_valid
);

  localparam int PW = $clog2(WIDTH);

  logic [MAXW-1:0] wide;

  always_comb begin
    wide = '0;
    wide[WIDTH-1:0] = onehot;
    phase_valid = is_onehot(wide);
    phase = '0;
    // OR of set-bit indices; only meaningful when one-hot, so forced to 0 otherwise.
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) phase = phase | PW'(i);
    end
    if (!phase_valid) phase = '0;
  end

endmodule

// File: rtl/ring_monitor.sv
// Purpose: observer of a one-hot ring counter: phase decode, lock FSM, revolution count, sticky errors.
// Latency: phase/phase_valid 1 cycle after ring_in; state/flags/rev_count 1 cycle after the step lands in s1.
// Backpressure: none; samples every cycle, never stalls the ring.
// Ports: clock, reset (async active-low), ring_in (WIDTH), clear (sync);
//        phase, phase_valid, rev_count, rev_pulse, locked, err_illegal, err_order, state.
module ring_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int REV_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     clear,
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic                     phase_valid,
  output logic [REV_W-1:0]         rev_count,
  output logic                     rev_pulse,
  output logic                     locked,
  output logic                     err_illegal,
  output logic                     err_order,
  output logic [1:0]               state
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  logic [WIDTH-1:0] s1, s2;
  state_t           state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic [REV_W-1:0] rev_d;
  logic             pulse_d, eil_d, eor_d;
  step_t            step;
  logic [MAXW-1:0]  s1w, s2w;

  ring_onehot_enc #(.WIDTH(WIDTH)) u_enc (
    .onehot      (s1),
    .phase       (phase),
    .phase_valid (phase_valid)
  );

  // Two-stage sample: s1 is the current step, s2 the one before it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ring_in;
      s2 <= s1;
    end
  end

  always_comb begin
    s1w = '0;
    s2w = '0;
    s1w[WIDTH-1:0] = s1;
    s2w[WIDTH-1:0] = s2;
    step = STEP_BAD_ORD;
    if (!phase_valid)                   step = STEP_BAD_PAT;
    else if (s1w == rotl1(s2w, WIDTH))  step = STEP_ADV;
    else if (s1 == s2)                  step = STEP_HOLD;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    rev_d   = rev_count;
    pulse_d = 1'b0;
    eil_d   = err_illegal;
    eor_d   = err_order;
    if (clear) begin
      state_d = ST_SYNC;
      good_d  = '0;
      rev_d   = '0;
      eil_d   = 1'b0;
      eor_d   = 1'b0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (phase_valid) begin
            state_d = ST_ACQ;
            good_d  = '0;
          end
        end
        ST_ACQ: begin
          case (step)
            STEP_ADV: begin
              good_d = good_q + GW'(1);
              if (good_q + GW'(1) == GW'(LOCK_CNT)) state_d = ST_LOCKED;
            end
            STEP_HOLD: ;
            default: begin
              // Losing sync before lock is expected during bring-up, not an error.
              state_d = ST_SYNC;
              good_d  = '0;
            end
          endcase
        end
        ST_LOCKED: begin
          case (step)
            STEP_ADV: begin
              if (s1[0]) begin
                rev_d   = rev_count + REV_W'(1);
                pulse_d = 1'b1;
              end
            end
            STEP_HOLD: ;
            STEP_BAD_PAT: begin
              eil_d   = 1'b1;
              state_d = ST_FAULT;
            end
            default: begin
              eor_d   = 1'b1;
              state_d = ST_FAULT;
            end
          endcase
        end
        default: ; // FAULT holds everything until clear
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SYNC;
      good_q      <= '0;
      rev_count   <= '0;
      rev_pulse   <= 1'b0;
      err_illegal <= 1'b0;
      err_order   <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      rev_count   <= rev_d;
      rev_pulse   <= pulse_d;
      err_illegal <= eil_d;
      err_order   <= eor_d;
    end
  end

  assign locked = (state_q == ST_LOCKED);
  assign state  = state_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Purpose: directed self-checking bench for ring_monitor (REV_W=8 and REV_W=2 instances on shared stimulus).
// Latency: checks taken 1 time unit after each rising edge.
// Backpressure: none.
module tb_ring_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] ring_in = 4'b0000;
  logic       clear = 1'b0;

  logic [1:0] phase8, state8;
  logic       pv8, pulse8, locked8, eil8, eor8;
  logic [7:0] rev8;

  logic [1:0] phase2, state2;
  logic       pv2, pulse2, locked2, eil2, eor2;
  logic [1:0] rev2;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;
  int pulses   = 0;

  always #5 clock = ~clock;

  ring_monitor #(.WIDTH(4), .REV_W(8), .LOCK_CNT(2)) dut8 (
    .clock(clock), .reset(reset), .ring_in(ring_in), .clear(clear),
    .phase(phase8), .phase_valid(pv8), .rev_count(rev8), .rev_pulse(pulse8),
    .locked(locked8), .err_illegal(eil8), .err_order(eor8), .state(state8)
  );

  ring_monitor #(.WIDTH(4), .REV_W(2), .LOCK_CNT(2)) dut2 (
    .clock(clock), .reset(reset), .ring_in(ring_in), .clear(clear),
    .phase(phase2), .phase_valid(pv2), .rev_count(rev2), .rev_pulse(pulse2),
    .locked(locked2), .err_illegal(eil2), .err_order(eor2), .state(state2)
  );

  typedef struct {
    logic [3:0] ring;
    logic [1:0] ph;
    logic       pv;
    logic [1:0] st;
    logic [7:0] rev;
    logic       pulse;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic [3:0] r, input logic c);
    ring_in = r;
    clear   = c;
    @(posedge clock);
    #1;
    clear   = 1'b0;
  endtask

  function automatic logic [3:0] ring_at(input int p);
    logic [3:0] v;
    v = 4'b0001;
    return v << p;
  endfunction

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      tick(ring_at(pos), 1'b0);
      pos = (pos + 1) % 4;
      if (pulse8) pulses++;
    end
  endtask

  task automatic wait_lock(input int budget, input string name);
    int n;
    n = 0;
    while (!locked8 && n < budget) begin
      run(1);
      n++;
    end
    check(name, {31'd0, locked8}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    int cyc;

    //             ring     ph    pv    st     rev   pulse
    tbl[0]  = '{4'b0001, 2'd0, 1'b1, 2'b00, 8'd0, 1'b0};
    tbl[1]  = '{4'b0010, 2'd1, 1'b1, 2'b01, 8'd0, 1'b0};
    tbl[2]  = '{4'b0100, 2'd2, 1'b1, 2'b01, 8'd0, 1'b0};
    tbl[3]  = '{4'b1000, 2'd3, 1'b1, 2'b10, 8'd0, 1'b0};
    tbl[4]  = '{4'b0001, 2'd0, 1'b1, 2'b10, 8'd0, 1'b0};
    tbl[5]  = '{4'b0010, 2'd1, 1'b1, 2'b10, 8'd1, 1'b1};
    tbl[6]  = '{4'b0100, 2'd2, 1'b1, 2'b10, 8'd1, 1'b0};
    tbl[7]  = '{4'b1000, 2'd3, 1'b1, 2'b10, 8'd1, 1'b0};
    tbl[8]  = '{4'b0001, 2'd0, 1'b1, 2'b10, 8'd1, 1'b0};
    tbl[9]  = '{4'b0010, 2'd1, 1'b1, 2'b10, 8'd2, 1'b1};
    tbl[10] = '{4'b0100, 2'd2, 1'b1, 2'b10, 8'd2, 1'b0};
    tbl[11] = '{4'b1000, 2'd3, 1'b1, 2'b10, 8'd2, 1'b0};
    tbl[12] = '{4'b0001, 2'd0, 1'b1, 2'b10, 8'd2, 1'b0};
    tbl[13] = '{4'b0010, 2'd1, 1'b1, 2'b10, 8'd3, 1'b1};
    tbl[14] = '{4'b0100, 2'd2, 1'b1, 2'b10, 8'd3, 1'b0};

    // Reset state: every output of both instances low.
    #2;
    check("reset_state",
          {phase8, pv8, rev8, pulse8, locked8, eil8, eor8, state8,
           phase2, pv2, rev2, pulse2, locked2, eil2, eor2, state2}, 32'd0);
    #10 reset = 1'b1;
    @(posedge clock);
    #1;

    // Acquire, lock and three revolutions, one vector per clock.
    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].ring, 1'b0);
      check($sformatf("vec%0d", i),
            {phase8, pv8, state8, locked8, rev8, pulse8, eil8, eor8},
            {tbl[i].ph, tbl[i].pv, tbl[i].st, (tbl[i].st == 2'b10), tbl[i].rev, tbl[i].pulse, 2'b00});
    end
    pos = 3;

    // Illegal pattern while locked.
    tick(4'b0110, 1'b0);
    check("illegal_sample", {phase8, pv8, state8, eil8}, {2'd0, 1'b0, 2'b10, 1'b0});
    tick(4'b1000, 1'b0);
    check("illegal_fault", {state8, eil8, eor8, rev8, pulse8}, {2'b11, 1'b1, 1'b0, 8'd3, 1'b0});
    pos = 0;
    pulses = 0;
    run(8);
    check("fault_frozen", {state8, eil8, rev8}, {2'b11, 1'b1, 8'd3});
    check("fault_no_pulse", pulses, 0);
    tick(ring_at(pos), 1'b1);
    pos = (pos + 1) % 4;
    check("clear_after_illegal", {state8, eil8, eor8, rev8, locked8}, {2'b00, 1'b0, 1'b0, 8'd0, 1'b0});
    wait_lock(12, "relock_after_illegal");

    // Out-of-order step 0010 -> 1000 while locked.
    while (pos != 2) run(1);
    tick(4'b1000, 1'b0);
    tick(4'b0001, 1'b0);
    check("order_fault", {state8, eil8, eor8}, {2'b11, 1'b0, 1'b1});
    pos = 1;
    tick(ring_at(0), 1'b1);
    wait_lock(12, "relock_after_order");

    // Five revolutions; the 2-bit counter wraps 1,2,3,0,1.
    seen = 0;
    cyc  = 0;
    while (seen < 5 && cyc < 40) begin
      run(1);
      cyc++;
      if (pulse8) begin
        check("rev_wrap", {rev8, pulse2, rev2}, {8'(seen + 1), 1'b1, 2'((seen + 1) % 4)});
        seen++;
      end
    end
    check("rev_wrap_count", seen, 5);

    // Ring frozen at 0100 for three cycles: tolerated, no count change.
    while (pos != 3) run(1);
    tick(4'b0100, 1'b0);
    tick(4'b0100, 1'b0);
    tick(4'b0100, 1'b0);
    check("hold_no_error", {state8, eil8, eor8, rev8, rev2, pulse8}, {2'b10, 1'b0, 1'b0, 8'd5, 2'd1, 1'b0});
    pos = 3;
    run(8);
    check("resume_after_hold", {rev8, rev2, state8}, {8'd7, 2'd3, 2'b10});

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    check("async_reset",
          {phase8, pv8, rev8, pulse8, locked8, eil8, eor8, state8,
           phase2, pv2, rev2, pulse2, locked2, eil2, eor2, state2}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    wait_lock(12, "relock_after_reset");

    // Clear coincident with an illegal sample wins.
    tick(4'b0110, 1'b0);
    tick(4'b0001, 1'b1);
    check("clear_vs_illegal", {state8, eil8, eor8, locked8}, {2'b00, 1'b0, 1'b0, 1'b0});
    tick(4'b0010, 1'b0);
    check("after_clear_acq", {state8, eil8, eor8}, {2'b01, 1'b0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_monitor.md
Name: ring_monitor

Overview:
- Downstream consumer of the 4-bit one-hot ring counter output.
- Registers the ring vector and encodes it to a binary phase index.
- Checks every step for legality, locks after a run of good steps, and counts full revolutions.
- Flags illegal (non-one-hot) patterns and out-of-order steps with sticky error bits, so bring-up and the bench get a self-checking observer of the ring.

Parameters:
- WIDTH, 4, ring length in bits (>=2).
- REV_W, 8, width of revolution counter.
- LOCK_CNT, 2, consecutive legal advancing steps needed to enter LOCKED (>=1).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
- ring_in  in  WIDTH  one-hot vector from ring counter.
- clear  in  1  synchronous: clears errors and rev_count, returns to SYNC.
- phase  out  $clog2(WIDTH)  index of set bit in sampled vector; 0 when not one-hot.
- phase_valid  out  1  sampled vector is exactly one-hot.
- rev_count  out  REV_W  completed revolutions while LOCKED, wraps modulo 2^REV_W.
- rev_pulse  out  1  one-cycle pulse on each counted revolution.
- locked  out  1  high in LOCKED state.
- err_illegal  out  1  sticky: non-one-hot sample seen while LOCKED.
- err_order  out  1  sticky: one-hot but wrong step seen while LOCKED.
- state  out  2  SYNC=00, ACQ=01, LOCKED=10, FAULT=11.

Behaviour:
- Reset (reset=0) values:
  - s1, s2 = 0; state = SYNC; good count = 0.
  - All outputs 0.
- Pipeline:
  - s1 <= ring_in each edge; s2 <= s1.
  - phase and phase_valid derive from s1, giving 1-cycle latency from ring_in.
- Step classification (combinational on s1, s2):
  - ADV: s1 is one-hot and s1 == rotate-left-by-1(s2), i.e. bit i to bit i+1, MSB to bit 0.
  - HOLD: s1 == s2 and one-hot. Tolerated; no progress, no error.
  - BAD_PAT: s1 not one-hot (zero or multiple bits set).
  - BAD_ORD: s1 one-hot, not ADV, not HOLD.
- FSM, next-state registered:
  - SYNC: phase_valid=1 moves to ACQ with good count 0; otherwise stay.
  - ACQ:
    - ADV increments good count; when it reaches LOCK_CNT, go to LOCKED.
    - HOLD: stay, count kept.
    - BAD_PAT or BAD_ORD: go to SYNC, count cleared, no error flag set.
  - LOCKED:
    - ADV with s1[0]=1 (wrap into bit 0): rev_count++ and rev_pulse=1 for one cycle.
    - BAD_PAT: err_illegal <= 1, go to FAULT.
    - BAD_ORD: err_order <= 1, go to FAULT.
  - FAULT: hold all flags and rev_count; leave only via clear.
- clear has priority over any same-cycle event in every state:
  - Next state is SYNC; err_* = 0, rev_count = 0, good count = 0, rev_pulse = 0.
  - s1/s2 keep sampling.
- rev_count wraps from 2^REV_W-1 to 0; the pulse still fires on wrap.
- rev_pulse is never asserted outside LOCKED.
- Timing of rev_count and rev_pulse: both register on the edge after the wrap sample lands in s1, so they update together.
- Asynchronous reset mid-operation: all state discarded immediately; on release the monitor reacquires from SYNC.
- An upstream ring held in its reset (constant pattern) is a HOLD, not an error.

Decomposition:
- Package ring_pkg holds:
  - state encoding localparams;
  - function is_onehot(vec);
  - function rotl1(vec);
  - step-class encoding ADV/HOLD/BAD_PAT/BAD_ORD.
- One sub-module: ring_onehot_enc, a parameterised WIDTH one-hot to binary encoder producing phase and phase_valid from s1.
- FSM, counters and flags stay in ring_monitor.

Test Plan:
- Reset, then drive 0001,0010,0100,1000 repeating, one per clock, LOCK_CNT=2 -> state SYNC to ACQ to LOCKED; locked=1 on the 4th edge after 0001 is first applied; phase follows 0,1,2,3 with 1-cycle lag.
- Let the ring run 3 full revolutions after lock -> rev_count=3; exactly three single-cycle rev_pulse, each one cycle after a 0001 reaches s1.
- While LOCKED, inject 0110 for one cycle -> err_illegal=1, state=FAULT, phase_valid=0 that cycle; rev_count frozen; pulse clear -> both flags 0, rev_count=0, state=SYNC, relock follows.
- While LOCKED, skip from 0010 to 1000 -> err_order=1, err_illegal=0, state=FAULT.
- REV_W=2: run 5 revolutions -> rev_count sequence 1,2,3,0,1 with a pulse each time; hold ring_in at 0100 for 3 cycles -> no error, rev_count unchanged.
- Assert reset low mid-revolution between edges -> all outputs 0 immediately; assert clear in the same cycle as an illegal sample -> no flag set, state=SYNC.
